// File: rtl/pixel_stream_receiver_if.sv
// Pixel input and frame-buffer write signals of the pixel stream receiver.
// The receiver uses the slave side; the pixel source / buffer model uses master.
interface pixel_stream_receiver_if #(
    parameter int ADDR_W = 17
);
    logic              horizontal_sync;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;

    modport master (
        output horizontal_sync, r, g, b,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  horizontal_sync, r, g, b,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pixel_stream_receiver.sv
// Captures one frame of sync-qualified RGB pixels into a frame buffer, storing
// rows bottom-up, and flags rows that end early or run past the row width.
module pixel_stream_receiver #(
    parameter int WIDTH  = 384,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 17
) (
    input  logic                   horizontal_clock,
    input  logic                   horizontal_reset,
    pixel_stream_receiver_if.slave pix,
    output logic [10:0]            row,
    output logic                   frame_done,
    output logic                   done,
    output logic                   short_error,
    output logic                   long_error
);

    localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_READY,
        S_ACTIVE,
        S_BLANK,
        S_DONE
    } state_t;

    state_t            state;
    logic [10:0]       col;

    logic              vld_p0;
    logic              last_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [23:0]       data_p0;

    logic              vld_p1;
    logic              last_p1;
    logic              done_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [23:0]       data_p1;

    // Row 0 lands in the last buffer row so the stored image is bottom-up.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [10:0] row_idx,
                                                     input logic [10:0] col_idx);
        logic [ADDR_W-1:0] flipped_row;
        flipped_row = ADDR_W'(HEIGHT - 1) - ADDR_W'(row_idx);
        return flipped_row * ADDR_W'(WIDTH) + ADDR_W'(col_idx);
    endfunction

    // Stage p0: row/column tracking and pixel acceptance
    always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
        if (!horizontal_reset) begin
            state       <= S_WAIT;
            row         <= '0;
            col         <= '0;
            short_error <= 1'b0;
            long_error  <= 1'b0;
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
            addr_p0     <= '0;
            data_p0     <= '0;
        end else begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    // A row already in flight at reset release is never captured.
                    if (!pix.horizontal_sync) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (pix.horizontal_sync) begin
                        vld_p0  <= 1'b1;
                        addr_p0 <= pixel_addr(row, 11'd0);
                        data_p0 <= {pix.r, pix.g, pix.b};
                        col     <= 11'd1;
                        state   <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (pix.horizontal_sync) begin
                        vld_p0  <= 1'b1;
                        addr_p0 <= pixel_addr(row, col);
                        data_p0 <= {pix.r, pix.g, pix.b};
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                last_p0 <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                row   <= row + 11'd1;
                                state <= S_BLANK;
                            end
                        end else begin
                            col <= col + 11'd1;
                        end
                    end else begin
                        // Short row: the same row index is retried from column 0.
                        short_error <= 1'b1;
                        col         <= '0;
                        state       <= S_READY;
                    end
                end
                S_BLANK: begin
                    if (pix.horizontal_sync) begin
                        long_error <= 1'b1;
                    end else begin
                        state <= S_READY;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

    // Stage p1: registered frame-buffer write port and frame status
    always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
        if (!horizontal_reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            done_p1 <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            if (last_p0) begin
                done_p1 <= 1'b1;
            end
            if (vld_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign pix.wr_en   = vld_p1;
    assign pix.wr_addr = addr_p1;
    assign pix.wr_data = data_p1;
    assign frame_done  = last_p1;
    assign done        = done_p1;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench for pixel_stream_receiver (WIDTH=4, HEIGHT=2) with a write
// scoreboard: expected writes are queued as pixels are driven and popped on wr_en.
module tb_pixel_stream_receiver;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 17;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
        logic              fd;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] row;
    logic frame_done, done, short_error, long_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_count = 0;
    exp_t sb[$];
    logic [ADDR_W-1:0] last_addr = '0;
    logic [23:0] last_data = '0;

    pixel_stream_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_stream_receiver #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) dut (
        .horizontal_clock(clk),
        .horizontal_reset(rst_n),
        .pix             (bus.slave),
        .row             (row),
        .frame_done      (frame_done),
        .done            (done),
        .short_error     (short_error),
        .long_error      (long_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_addr = '0;
            last_data = '0;
        end else begin
            if (bus.wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 64'(bus.wr_addr), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(e.data));
                    check("frame_done_at_write", 64'(frame_done), 64'(e.fd));
                    check("write_latency", 64'(cyc), 64'(e.cyc));
                end
                last_addr = bus.wr_addr;
                last_data = bus.wr_data;
            end else begin
                check("idle_wr_en", 64'(bus.wr_en), 64'd0);
                check("hold_addr", 64'(bus.wr_addr), 64'(last_addr));
                check("hold_data", 64'(bus.wr_data), 64'(last_data));
                check("idle_frame_done", 64'(frame_done), 64'd0);
            end
            if (frame_done === 1'b1) fd_count++;
        end
    end

    task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                       input bit wr, input logic [ADDR_W-1:0] addr, input bit fd);
        exp_t e;
        bus.horizontal_sync = 1'b1;
        bus.r = rr;
        bus.g = gg;
        bus.b = bb;
        if (wr) begin
            e.addr = addr;
            e.data = {rr, gg, bb};
            e.fd   = fd;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        bus.horizontal_sync = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.r = 8'($urandom);
            bus.g = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.horizontal_sync = 1'b0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
        check({tag, "_row"}, 64'(row), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_short_error"}, 64'(short_error), 64'd0);
        check({tag, "_long_error"}, 64'(long_error), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        check({tag, "_pending"}, 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Row 0 at addresses 4..7, blank, row 1 at addresses 0..3 with frame_done on the last.
    task automatic full_frame(input logic [7:0] gb, input int gap);
        for (int i = 0; i < 4; i++) pix(8'(i + 1), gb, gb + 8'h10, 1'b1, ADDR_W'(4 + i), 1'b0);
        blank(gap);
        for (int i = 0; i < 4; i++) pix(8'(i + 5), gb, gb + 8'h10, 1'b1, ADDR_W'(i), i == 3);
    endtask

    task automatic check_end(input string tag, input int fd0, input bit se, input bit le);
        check({tag, "_frame_done_count"}, 64'(fd_count - fd0), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_short_error"}, 64'(short_error), 64'(se));
        check({tag, "_long_error"}, 64'(long_error), 64'(le));
    endtask

    initial begin
        int fd0;
        bus.horizontal_sync = 1'b0;
        bus.r = '0;
        bus.g = '0;
        bus.b = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");

        // Clean frame
        rst_n = 1'b1;
        fd0 = fd_count;
        blank(2);
        full_frame(8'h10, 3);
        drain("clean_drain");
        check_end("clean", fd0, 1'b0, 1'b0);
        check("clean_row", 64'(row), 64'd1);
        pix(8'hAA, 8'hBB, 8'hCC, 1'b0, '0, 1'b0);
        pix(8'hAB, 8'hBC, 8'hCD, 1'b0, '0, 1'b0);
        drain("done_ignores_input");
        check("done_sticky", 64'(done), 64'd1);

        // Release with sync high: partial row ignored
        do_reset("rst_b");
        bus.horizontal_sync = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) pix(8'hE0 + 8'(i), 8'h33, 8'h44, 1'b0, '0, 1'b0);
        fd0 = fd_count;
        blank(1);
        full_frame(8'h21, 2);
        drain("partial_drain");
        check_end("partial", fd0, 1'b0, 1'b0);

        // Short row, retried at the same row index
        do_reset("rst_c");
        rst_n = 1'b1;
        fd0 = fd_count;
        blank(1);
        pix(8'h71, 8'h02, 8'h03, 1'b1, ADDR_W'(4), 1'b0);
        pix(8'h72, 8'h02, 8'h03, 1'b1, ADDR_W'(5), 1'b0);
        blank(1);
        check("short_flag", 64'(short_error), 64'd1);
        check("short_row_kept", 64'(row), 64'd0);
        for (int i = 0; i < 3; i++) pix(8'h80 + 8'(i), 8'h04, 8'h05, 1'b1, ADDR_W'(4 + i), 1'b0);
        check("retry_row_before_last", 64'(row), 64'd0);
        pix(8'h83, 8'h04, 8'h05, 1'b1, ADDR_W'(7), 1'b0);
        check("retry_row_after_last", 64'(row), 64'd1);
        blank(1);
        for (int i = 0; i < 4; i++) pix(8'h90 + 8'(i), 8'h06, 8'h07, 1'b1, ADDR_W'(i), i == 3);
        drain("short_drain");
        check_end("short", fd0, 1'b1, 1'b0);

        // Long row: extra pixels dropped
        do_reset("rst_d");
        rst_n = 1'b1;
        fd0 = fd_count;
        blank(1);
        for (int i = 0; i < 6; i++) pix(8'hC0 + 8'(i), 8'h55, 8'h66, i < 4, ADDR_W'(4 + i), 1'b0);
        check("long_flag", 64'(long_error), 64'd1);
        check("long_row", 64'(row), 64'd1);
        blank(1);
        for (int i = 0; i < 4; i++) pix(8'hD0 + 8'(i), 8'h55, 8'h66, 1'b1, ADDR_W'(i), i == 3);
        drain("long_drain");
        check_end("long", fd0, 1'b0, 1'b1);

        // Reset in the middle of a frame, right after the fifth pixel
        do_reset("rst_e");
        rst_n = 1'b1;
        blank(1);
        for (int i = 0; i < 4; i++) pix(8'hF0 + 8'(i), 8'h01, 8'h02, 1'b1, ADDR_W'(4 + i), 1'b0);
        blank(1);
        pix(8'hF4, 8'h01, 8'h02, 1'b0, '0, 1'b0);
        check("mid_row_before_reset", 64'(row), 64'd1);
        do_reset("mid_frame_reset");
        rst_n = 1'b1;
        fd0 = fd_count;
        blank(1);
        full_frame(8'h42, 5);
        drain("after_reset_drain");
        check_end("after_reset", fd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_receiver.md
PIXEL_STREAM_RECEIVER -- requirements
Module: pixel_stream_receiver

Interface
REQ-001 Parameter WIDTH, default 384, pixels per row (legal range 2..2047).
REQ-002 Parameter HEIGHT, default 256, rows per frame (legal range 1..2047).
REQ-003 Parameter ADDR_W, default 17, write-address width (2^ADDR_W SHALL be >= WIDTH*HEIGHT).
REQ-004 horizontal_clock  input  1  single clock; all state changes on its rising edge.
REQ-005 horizontal_reset  input  1  asynchronous, active-low reset.
REQ-006 horizontal_sync  input  1  pixel-valid qualifier; high = r/g/b carry one pixel this cycle, low = blanking.
REQ-007 r, g, b  input  8 each  pixel components, sampled only when horizontal_sync=1.
REQ-008 wr_en  output  1  frame-buffer write strobe, one cycle per accepted pixel.
REQ-009 wr_addr  output  ADDR_W  frame-buffer word address.
REQ-010 wr_data  output  24  {r,g,b}; r in [23:16], g in [15:8], b in [7:0].
REQ-011 row  output  11  index of the row currently being received.
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of the frame is written.
REQ-013 done  output  1  level; high from frame_done until reset.
REQ-014 short_error  output  1  sticky; a row ended before WIDTH pixels.
REQ-015 long_error  output  1  sticky; more than WIDTH consecutive valid pixels.

Function
REQ-016 FSM states SHALL be S_WAIT, S_READY, S_ACTIVE, S_BLANK, S_DONE; internal column counter col (11 bits).
REQ-017 S_WAIT: sync=0 -> S_READY; sync=1 -> stay, pixel ignored (no capture of a partial row after reset release).
REQ-018 S_READY: sync=0 -> stay; sync=1 -> accept pixel at col=0, col<=1, -> S_ACTIVE.
REQ-019 S_ACTIVE, sync=1, col<WIDTH-1: accept pixel, col<=col+1, stay.
REQ-020 S_ACTIVE, sync=1, col==WIDTH-1: accept pixel, col<=0; if row==HEIGHT-1 -> S_DONE, else row<=row+1, -> S_BLANK.
REQ-021 S_ACTIVE, sync=0 (col>0 by construction): short_error<=1, col<=0, row unchanged (row restarts), -> S_READY; already-written pixels are not retracted.
REQ-022 S_BLANK: sync=1 -> long_error<=1, pixel ignored, stay; sync=0 -> S_READY.
REQ-023 S_DONE: all input ignored, no writes, stay until reset.
REQ-024 Accepted pixel on edge N SHALL produce wr_en=1 with its wr_addr/wr_data after edge N+1 (latency 1, registered outputs); wr_en=0 on all other cycles.
REQ-025 wr_addr = (HEIGHT-1-row)*WIDTH + col, using row/col values at acceptance (bottom-up row storage), computed at ADDR_W width with no truncation for legal parameters.
REQ-026 wr_data and wr_addr SHALL hold last value when wr_en=0.
REQ-027 frame_done SHALL assert in the same cycle as wr_en for the last pixel (row HEIGHT-1, col WIDTH-1); done rises in that same cycle.
REQ-028 If HEIGHT==1, REQ-020 SHALL go directly to S_DONE after the first full row.
REQ-029 Blanking length is unconstrained (minimum one sync-low cycle between rows).

Reset
REQ-030 horizontal_reset=0 SHALL immediately force: state S_WAIT, row=0, col=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, done=0, short_error=0, long_error=0.
REQ-031 Reset asserted mid-row or mid-frame SHALL discard progress; after release, capture resumes only via S_WAIT -> S_READY.
REQ-032 Reset release is synchronous-safe: first state change no earlier than the first rising edge after deassertion.

Verification (WIDTH=4, HEIGHT=2 unless stated)
REQ-033 Reset, sync=0 2 cycles, 4 pixels (r=1..4,g=0x10,b=0x20), 3 blank, 4 pixels (r=5..8) -> writes addr 4,5,6,7 then 0,1,2,3, data 0x011020.., frame_done once one cycle after the 8th pixel edge, done=1, errors 0.
REQ-034 Release reset with sync=1 for 3 cycles, then low, then full frame -> first 3 pixels not written; frame captured as REQ-033.
REQ-035 Row 0 sends 2 pixels then sync low, then 4 pixels -> writes addr 4,5 then 4,5,6,7; short_error=1; row=0 until 4th pixel of retry.
REQ-036 Row 0 sends 6 consecutive pixels -> writes addr 4..7 only, long_error=1, row=1, next row after blank writes 0..3.
REQ-037 Reset pulsed after 5 pixels of frame -> all outputs to reset values at once; subsequent full frame writes 4..7, 0..3 with done=1.
REQ-038 WIDTH=384, HEIGHT=256, 160-cycle blanks (matching the existing pixel source) -> 98304 writes, first addr 97920, last addr 383, single frame_done, no errors.
